// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller:
// refresh default, blank pattern and the hex-to-cathode table.
package display_pkg;

  localparam int REFRESH_DIV_DEFAULT = 100000;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low cathodes {g,f,e,d,c,b,a}; entry n decodes hex digit n.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment cathode decoder.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG_TABLE[hex_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a one-deep load buffer
// that only commits on frame boundaries, plus leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        blank_lz,
  input  logic [3:0]  dp_in,
  output logic [1:0]  anode_driver,
  output logic [6:0]  seg_out,
  output logic        dp_out
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  digit_idx_t    anode_q, anode_d;
  logic          pending_q, pending_d;
  logic [15:0]   pending_data_q, pending_data_d;
  logic [15:0]   display_q, display_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          frame_end;
  logic          xfer;
  logic [3:0]    lz_blank;
  logic [3:0]    digit_nibble;
  logic [6:0]    digit_seg;

  always_comb begin
    tick           = (prescaler_q == PRESCALE_LAST);
    frame_end      = tick && (anode_q == 2'd3);
    xfer           = load_valid && !pending_q;
    prescaler_d    = tick ? '0 : prescaler_q + 1'b1;
    anode_d        = tick ? anode_q + 2'd1 : anode_q;
    pending_d      = pending_q;
    pending_data_d = pending_data_q;
    display_d      = display_q;
    // Commit and accept are mutually exclusive: accept needs pending low.
    if (frame_end && pending_q) begin
      display_d = pending_data_q;
      pending_d = 1'b0;
    end else if (xfer) begin
      pending_d      = 1'b1;
      pending_data_d = load_data;
    end
  end

  // Digit i blanks when it and every more-significant nibble are zero.
  assign lz_blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      assign lz_blank[gi] = blank_lz && (display_d[15:4*gi] == '0);
    end
  endgenerate

  // Decode from next-state values so cathodes land with their anode.
  assign digit_nibble = display_d[{anode_d, 2'b00} +: 4];

  hex_to_7seg u_hex (
    .hex_i (digit_nibble),
    .seg_o (digit_seg)
  );

  always_comb begin
    seg_d = digit_seg;
    dp_d  = ~dp_in[anode_d];
    if (lz_blank[anode_d]) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q    <= '0;
      anode_q        <= '0;
      pending_q      <= 1'b0;
      pending_data_q <= '0;
      display_q      <= '0;
      seg_q          <= HEX_SEG_TABLE[0];
      dp_q           <= 1'b1;
    end else begin
      prescaler_q    <= prescaler_d;
      anode_q        <= anode_d;
      pending_q      <= pending_d;
      pending_data_q <= pending_data_d;
      display_q      <= display_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign load_ready   = ~pending_q;
  assign anode_driver = anode_q;
  assign seg_out      = seg_q;
  assign dp_out       = dp_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a 4-cycle digit period:
// scan table, load/commit, blanking, backpressure and async reset cases.
module tb_display_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        blank_lz;
  logic [3:0]  dp_in;
  logic [1:0]  anode_driver;
  logic [6:0]  seg_out;
  logic        dp_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .blank_lz     (blank_lz),
    .dp_in        (dp_in),
    .anode_driver (anode_driver),
    .seg_out      (seg_out),
    .dp_out       (dp_out)
  );

  typedef struct {
    logic [3:0] dp_in;
    logic [1:0] exp_anode;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[20];
  int   n_vecs = 0;

  task automatic add_vec(input logic [3:0] d, input logic [1:0] a,
                         input logic [6:0] s, input logic p);
    vecs[n_vecs] = '{d, a, s, p, 1'b1};
    n_vecs++;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_anode(input logic [1:0] target, input string name);
    for (int i = 0; i < 100 && anode_driver !== target; i++) step();
    check(name, 16'(anode_driver), 16'(target));
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 100 && load_ready !== 1'b1; i++) step();
    check(name, 16'(load_ready), 16'd1);
  endtask

  task automatic expect_digit(input logic [1:0] k, input logic [6:0] s,
                              input logic p, input string tag);
    wait_anode(k, $sformatf("%s_d%0d_anode", tag, k));
    check($sformatf("%s_d%0d_seg", tag, k), 16'(seg_out), 16'(s));
    check($sformatf("%s_d%0d_dp", tag, k), 16'(dp_out), 16'(p));
    $display("digit %0d (%s): seg=%b dp=%b", k, tag, seg_out, dp_out);
  endtask

  task automatic send(input logic [15:0] d);
    load_valid = 1'b1;
    load_data  = d;
    step();
    load_valid = 1'b0;
    $display("load %h presented at cycle %0d", d, cyc);
  endtask

  int c1, c2;

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    blank_lz   = 1'b0;
    dp_in      = 4'b0000;

    // Scan table: entry n is the state sampled after the n-th edge after release.
    for (int n = 1; n <= 3; n++)   add_vec(4'b0101, 2'd0, 7'b1000000, 1'b0);
    for (int n = 4; n <= 7; n++)   add_vec(4'b0101, 2'd1, 7'b1000000, 1'b1);
    for (int n = 8; n <= 10; n++)  add_vec(4'b0101, 2'd2, 7'b1000000, 1'b0);
    add_vec(4'b1010, 2'd2, 7'b1000000, 1'b1);
    for (int n = 12; n <= 15; n++) add_vec(4'b1010, 2'd3, 7'b1000000, 1'b0);
    for (int n = 16; n <= 19; n++) add_vec(4'b1010, 2'd0, 7'b1000000, 1'b1);
    add_vec(4'b1010, 2'd1, 7'b1000000, 1'b0);

    repeat (3) @(negedge clk);
    check("rst_anode", 16'(anode_driver), 16'd0);
    check("rst_seg", 16'(seg_out), 16'b1000000);
    check("rst_dp", 16'(dp_out), 16'd1);
    check("rst_ready", 16'(load_ready), 16'd1);
    $display("reset: anode=%0d seg=%b dp=%b ready=%b", anode_driver, seg_out, dp_out, load_ready);
    rst_n = 1'b1;

    for (int i = 0; i < n_vecs; i++) begin
      dp_in = vecs[i].dp_in;
      step();
      check($sformatf("scan%0d_anode", i + 1), 16'(anode_driver), 16'(vecs[i].exp_anode));
      check($sformatf("scan%0d_seg", i + 1), 16'(seg_out), 16'(vecs[i].exp_seg));
      check($sformatf("scan%0d_dp", i + 1), 16'(dp_out), 16'(vecs[i].exp_dp));
      check($sformatf("scan%0d_ready", i + 1), 16'(load_ready), 16'(vecs[i].exp_ready));
      $display("vec %0d: anode=%0d seg=%b dp=%b", i + 1, anode_driver, seg_out, dp_out);
    end
    dp_in = 4'b0000;

    // Load while digit 1 is shown; commit only at the 3->0 wrap.
    check("load_start_anode", 16'(anode_driver), 16'd1);
    send(16'h12AF);
    check("load_ready_low", 16'(load_ready), 16'd0);
    wait_anode(2'd3, "load_wait_d3");
    check("load_ready_low_d3", 16'(load_ready), 16'd0);
    wait_ready("load_commit");
    check("load_commit_anode", 16'(anode_driver), 16'd0);
    expect_digit(2'd0, 7'b0001110, 1'b1, "load");
    expect_digit(2'd1, 7'b0001000, 1'b1, "load");
    expect_digit(2'd2, 7'b0100100, 1'b1, "load");
    expect_digit(2'd3, 7'b1111001, 1'b1, "load");

    // Leading-zero blanking, with dp requested on every digit.
    blank_lz = 1'b1;
    dp_in    = 4'b1111;
    send(16'h0005);
    wait_ready("blank5_commit");
    expect_digit(2'd0, 7'b0010010, 1'b0, "blank5");
    expect_digit(2'd1, 7'b1111111, 1'b1, "blank5");
    expect_digit(2'd2, 7'b1111111, 1'b1, "blank5");
    expect_digit(2'd3, 7'b1111111, 1'b1, "blank5");
    send(16'h0000);
    wait_ready("blank0_commit");
    expect_digit(2'd0, 7'b1000000, 1'b0, "blank0");
    expect_digit(2'd1, 7'b1111111, 1'b1, "blank0");

    // Backpressure: second value waits for the first to commit.
    blank_lz   = 1'b0;
    dp_in      = 4'b0000;
    load_valid = 1'b1;
    load_data  = 16'h1111;
    step();
    $display("load 1111 presented at cycle %0d", cyc);
    check("bp_first_taken", 16'(load_ready), 16'd0);
    load_data = 16'h2222;
    wait_ready("bp_first_commit");
    c1 = cyc;
    check("bp_first_anode", 16'(anode_driver), 16'd0);
    check("bp_first_seg", 16'(seg_out), 16'b1111001);
    step();
    load_valid = 1'b0;
    $display("load 2222 presented at cycle %0d", cyc);
    check("bp_second_taken", 16'(load_ready), 16'd0);
    expect_digit(2'd1, 7'b1111001, 1'b1, "bp_hold");
    expect_digit(2'd2, 7'b1111001, 1'b1, "bp_hold");
    expect_digit(2'd3, 7'b1111001, 1'b1, "bp_hold");
    wait_ready("bp_second_commit");
    c2 = cyc;
    check("bp_frame_gap", 16'(c2 - c1), 16'(4 * DIV));
    check("bp_second_seg", 16'(seg_out), 16'b0100100);

    // Asynchronous reset while a value is pending: it must be discarded.
    send(16'h3333);
    check("rst_mid_pending", 16'(load_ready), 16'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 16'(load_ready), 16'd1);
    check("rst_mid_anode", 16'(anode_driver), 16'd0);
    check("rst_mid_seg", 16'(seg_out), 16'b1000000);
    check("rst_mid_dp", 16'(dp_out), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    expect_digit(2'd0, 7'b1000000, 1'b1, "postrst");
    expect_digit(2'd1, 7'b1000000, 1'b1, "postrst");
    expect_digit(2'd2, 7'b1000000, 1'b1, "postrst");
    expect_digit(2'd3, 7'b1000000, 1'b1, "postrst");
    expect_digit(2'd0, 7'b1000000, 1'b1, "postrst_wrap");
    check("postrst_ready", 16'(load_ready), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL be the number of clk cycles each digit is held; legal range is 2 or more.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 load_valid  input  1  SHALL indicate that load_data holds a new 16-bit display value.
REQ-005 load_data  input  16  SHALL carry four hex nibbles; nibble i (bits 4i+3:4i) is shown on digit i.
REQ-006 load_ready  output  1  SHALL indicate that the block can accept a value.
REQ-007 blank_lz  input  1  SHALL enable leading-zero blanking when high.
REQ-008 dp_in  input  4  SHALL request the decimal point per digit, active-high, sampled live.
REQ-009 anode_driver  output  2  SHALL be the current digit index, feeding the downstream anode decoder.
REQ-010 seg_out  output  7  SHALL be the active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-011 dp_out  output  1  SHALL be the active-low decimal-point cathode.

Function
REQ-012 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap, asserting an internal tick on the cycle it holds REFRESH_DIV-1.
REQ-013 On each tick, anode_driver SHALL increment modulo 4, wrapping 3->0.
REQ-014 A frame boundary SHALL be a tick while anode_driver==3.
REQ-015 load_ready SHALL equal NOT pending, where pending is an internal flag.
REQ-016 A transfer SHALL occur when load_valid and load_ready are both high on a clock edge; load_data is then captured into pending_reg and pending is set.
REQ-017 While pending is high, load_valid SHALL be ignored; the source holds the value until load_ready returns high.
REQ-018 At a frame boundary with pending high, display_reg SHALL take pending_reg and pending SHALL clear on the same edge.
REQ-019 A transfer coinciding with a frame boundary SHALL commit at the next frame boundary; no bypass path exists.
REQ-020 display_reg changes only at frame boundaries, so no partially updated frame is ever displayed.
REQ-021 seg_out and dp_out SHALL be registered and SHALL update on the same edge as anode_driver, always matching the digit it selects.
REQ-022 Hex decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 With blank_lz high, digit i (i=1..3) SHALL be blanked when nibbles 3 down to i of display_reg are all zero; digit 0 is never blanked.
REQ-024 A blanked digit SHALL drive seg_out=1111111 and dp_out=1, regardless of dp_in.
REQ-025 An unblanked digit SHALL drive dp_out = NOT dp_in[anode_driver].

Reset
REQ-026 When rst_n is low, the following SHALL hold:
- prescaler = 0
- anode_driver = 0
- display_reg = 0
- pending_reg = 0
- pending = 0, so load_ready = 1
- seg_out = 1000000
- dp_out = 1
REQ-027 On assertion of rst_n mid-frame or mid-transfer, all state SHALL return to the reset values, and an uncommitted pending value SHALL be discarded.
REQ-028 The first tick after reset release SHALL occur REFRESH_DIV cycles after the release.

Structure
REQ-029 A shared package display_pkg SHALL hold:
- the REFRESH_DIV default
- the SEG_BLANK constant (1111111)
- the 16-entry hex-to-segment constant table
REQ-030 Hex decoding SHALL be a combinational sub-module hex_to_7seg (4-bit in, 7-bit out), instantiated once.

Verification
REQ-031 The bench SHALL cover the following directed scenarios, all with REFRESH_DIV=4:
- Reset: rst_n low -> anode_driver=0, seg_out=1000000, dp_out=1, load_ready=1.
- Scan: free-run 20 cycles after reset -> anode_driver steps 0,1,2,3,0, changing every 4 cycles; seg_out=1000000 on every digit with blank_lz=0.
- Load: pulse load_valid with 16'h12AF while anode_driver=1 -> load_ready=0 until the 3->0 wrap; afterwards digits 0..3 show 0001110, 0001000, 0100100, 1111001.
- Blanking: blank_lz=1, load 16'h0005 -> digits 3,2,1 show 1111111; digit 0 shows 0010010. Load 16'h0000 -> digit 0 shows 1000000.
- Backpressure: hold load_valid with 16'h1111 then 16'h2222 -> the second value is accepted only after the first commits; it appears one frame later.
- Reset mid-transfer: pending high, rst_n pulsed low -> display stays 0000 and load_ready=1.
